stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 137 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: 1 ms prescaler, synchronised and debounced start/clear
// buttons, and an IDLE/RUN/PAUSE state machine that drives a timer's enables.
module stopwatch_ctrl #(
    parameter int CLK_PER_MS  = 160,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic       I_CLK,
    input  logic       I_RST,
    input  logic       I_BTN_START,
    input  logic       I_BTN_CLEAR,
    output logic       O_EN_1MS,
    output logic       O_START_EN,
    output logic       O_CLEAR_EN,
    output logic [1:0] O_STATE
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_e;

    localparam logic [9:0] PRESC_MAX = 10'(CLK_PER_MS - 1);
    localparam logic [5:0] DEB_LAST  = 6'(DEBOUNCE_MS - 1);

    localparam int BTN_START = 0;
    localparam int BTN_CLEAR = 1;

    logic [9:0]      presc_q, presc_d;
    logic            en_1ms_q, en_1ms_d;
    logic [1:0]      btn_raw;
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      stable_q, stable_d;
    logic [1:0][5:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]      press;

    state_e state_q;
    logic   start_en_q;
    logic   clear_en_q;

    assign btn_raw = {I_BTN_CLEAR, I_BTN_START};

    // The tick is registered from the next prescaler value, so it is high
    // exactly while the prescaler holds CLK_PER_MS-1.
    always_comb begin
        presc_d  = (presc_q == PRESC_MAX) ? '0 : presc_q + 10'd1;
        en_1ms_d = (presc_d == PRESC_MAX);
    end

    // A press is the tick on which a low stable level is about to toggle high,
    // so the FSM reacts on the same edge that commits the new stable level.
    always_comb begin
        stable_d  = stable_q;
        deb_cnt_d = '0;
        press     = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                deb_cnt_d[i] = deb_cnt_q[i];
                if (en_1ms_q) begin
                    if (deb_cnt_q[i] == DEB_LAST) begin
                        stable_d[i]  = ~stable_q[i];
                        deb_cnt_d[i] = '0;
                        press[i]     = ~stable_q[i];
                    end else begin
                        deb_cnt_d[i] = deb_cnt_q[i] + 6'd1;
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others (synchronizer chain).
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            presc_q   <= '0;
            en_1ms_q  <= 1'b0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            deb_cnt_q <= '0;
        end else begin
            presc_q   <= presc_d;
            en_1ms_q  <= en_1ms_d;
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // Clear has priority over start except in RUN, where clear is ignored.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q    <= ST_IDLE;
            start_en_q <= 1'b0;
            clear_en_q <= 1'b0;
        end else begin
            clear_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (press[BTN_CLEAR]) begin
                        clear_en_q <= 1'b1;
                    end else if (press[BTN_START]) begin
                        state_q    <= ST_RUN;
                        start_en_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (press[BTN_START]) begin
                        state_q    <= ST_PAUSE;
                        start_en_q <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (press[BTN_CLEAR]) begin
                        state_q    <= ST_IDLE;
                        clear_en_q <= 1'b1;
                    end else if (press[BTN_START]) begin
                        state_q    <= ST_RUN;
                        start_en_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    start_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign O_EN_1MS   = en_1ms_q;
    assign O_START_EN = start_en_q;
    assign O_CLEAR_EN = clear_en_q;
    assign O_STATE    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl (CLK_PER_MS=16, DEBOUNCE_MS=3): directed
// button vectors push expected output changes; a negedge monitor pops and compares.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_clear = 1'b0;
    logic       en_1ms;
    logic       start_en;
    logic       clear_en;
    logic [1:0] state;

    stopwatch_ctrl #(
        .CLK_PER_MS (16),
        .DEBOUNCE_MS(3)
    ) dut (
        .I_CLK      (clk),
        .I_RST      (rst),
        .I_BTN_START(btn_start),
        .I_BTN_CLEAR(btn_clear),
        .O_EN_1MS   (en_1ms),
        .O_START_EN (start_en),
        .O_CLEAR_EN (clear_en),
        .O_STATE    (state)
    );

    always #5 clk = ~clk;

    // Rising edges since the last reset edge; edge n after release gives cyc == n.
    int cyc = 0;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int errors = 0;
    int checks = 0;
    bit run_checks = 1'b0;

    typedef struct {
        int         at_cyc;
        logic [3:0] outs;   // {state, start_en, clear_en}
    } exp_t;

    exp_t       sb[$];
    exp_t       cur_exp;
    logic [3:0] prev_outs;
    logic [3:0] cur_outs;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    task automatic expect_evt(input int at, input logic [1:0] s, input logic se, input logic ce);
        exp_t e;
        e.at_cyc = at;
        e.outs   = {s, se, ce};
        sb.push_back(e);
    endtask

    // Drive so that the value is first sampled by rising edge n.
    task automatic wait_to(input int n);
        if (cyc > n - 1) begin
            $display("FAIL wait_to: target edge %0d already passed (cyc %0d)", n, cyc);
            $fatal(1, "stimulus schedule broken");
        end
        while (cyc < n - 1) @(negedge clk);
    endtask

    // Monitor: tick pulses follow a simple period model; every change of the
    // control outputs must match the head of the scoreboard, value and edge.
    always @(negedge clk) begin
        if (run_checks) begin
            check("en_1ms", {31'd0, en_1ms}, {31'd0, (cyc % 16 == 15)});
            cur_outs = {state, start_en, clear_en};
            if (cur_outs !== prev_outs) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_change at cyc %0d: got %0h, expected %0h",
                             cyc, cur_outs, prev_outs);
                end else begin
                    cur_exp = sb.pop_front();
                    check("outs", {28'd0, cur_outs}, {28'd0, cur_exp.outs});
                    check("event_edge", cyc, cur_exp.at_cyc);
                end
                prev_outs = cur_outs;
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_en_1ms", {31'd0, en_1ms}, 32'd0);
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_start_en", {31'd0, start_en}, 32'd0);
        check("rst_clear_en", {31'd0, clear_en}, 32'd0);
        rst       = 1'b0;
        prev_outs = {state, start_en, clear_en};
        run_checks = 1'b1;

        // Idle ticks only (pulses at edges 16, 32, 48 sampled by the tick model).
        // Start held 5 ms: ticks 64, 80, 96 -> RUN at 96.
        wait_to(52);  btn_start = 1'b1; expect_evt(96, 2'b01, 1'b1, 1'b0);
        wait_to(132); btn_start = 1'b0;
        wait_to(200); btn_start = 1'b1; expect_evt(240, 2'b10, 1'b0, 1'b0);
        wait_to(260); btn_start = 1'b0;

        // Bounce every 8 clocks for 4 ms: every tick sees a low level.
        for (int k = 0; k < 8; k++) begin
            wait_to(320 + 8 * k);
            btn_start = (k % 2 == 0);
        end
        wait_to(400); btn_start = 1'b1; expect_evt(448, 2'b01, 1'b1, 1'b0);
        wait_to(460); btn_start = 1'b0;

        // Clear in RUN is ignored.
        wait_to(520); btn_clear = 1'b1;
        wait_to(580); btn_clear = 1'b0;
        wait_to(640); btn_start = 1'b1; expect_evt(688, 2'b10, 1'b0, 1'b0);
        wait_to(700); btn_start = 1'b0;

        // Clear in PAUSE: one-clock pulse and back to IDLE.
        wait_to(760); btn_clear = 1'b1;
        expect_evt(800, 2'b00, 1'b0, 1'b1);
        expect_evt(801, 2'b00, 1'b0, 1'b0);
        wait_to(820); btn_clear = 1'b0;

        // Into PAUSE again, then both buttons together: clear wins.
        wait_to(880);  btn_start = 1'b1; expect_evt(928, 2'b01, 1'b1, 1'b0);
        wait_to(940);  btn_start = 1'b0;
        wait_to(1000); btn_start = 1'b1; expect_evt(1040, 2'b10, 1'b0, 1'b0);
        wait_to(1050); btn_start = 1'b0;
        wait_to(1100); btn_start = 1'b1; btn_clear = 1'b1;
        expect_evt(1136, 2'b00, 1'b0, 1'b1);
        expect_evt(1137, 2'b00, 1'b0, 1'b0);
        wait_to(1150); btn_start = 1'b0; btn_clear = 1'b0;

        // Clear in IDLE: pulse, state stays IDLE.
        wait_to(1190); btn_clear = 1'b1;
        expect_evt(1232, 2'b00, 1'b0, 1'b1);
        expect_evt(1233, 2'b00, 1'b0, 1'b0);
        wait_to(1240); btn_clear = 1'b0;

        // Both buttons in RUN: start taken, clear ignored.
        wait_to(1300); btn_start = 1'b1; expect_evt(1344, 2'b01, 1'b1, 1'b0);
        wait_to(1350); btn_start = 1'b0;
        wait_to(1400); btn_start = 1'b1; btn_clear = 1'b1;
        expect_evt(1440, 2'b10, 1'b0, 1'b0);
        wait_to(1450); btn_start = 1'b0; btn_clear = 1'b0;

        // Reset in RUN with debounce count 2 (ticks 1616, 1632), button held on.
        wait_to(1500); btn_start = 1'b1; expect_evt(1536, 2'b01, 1'b1, 1'b0);
        wait_to(1550); btn_start = 1'b0;
        wait_to(1600); btn_start = 1'b1;
        wait_to(1640); rst = 1'b1;
        expect_evt(0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        // Held button restarts debounce from zero: ticks 16, 32, 48 -> RUN at 48.
        expect_evt(48, 2'b01, 1'b1, 1'b0);
        wait_to(60);  btn_start = 1'b0;
        wait_to(110);
        @(negedge clk);
        run_checks = 1'b0;

        check("sb_drain", sb.size(), 32'd0);
        check("final_state", {30'd0, state}, 32'd1);
        check("final_start_en", {31'd0, start_en}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
